// File: rtl/round_timer.sv
// BCD countdown round timer: one-cycle registered response to button pulses and 1 Hz edges.
// No backpressure; simultaneous events resolve by priority rst > start > solved > pause > tick.
module round_timer #(
  parameter int ROUND_SECS = 60,
  parameter int WARN_SECS  = 10
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       clk_blink,
  input  logic       start,
  input  logic       pause,
  input  logic       solved,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       paused,
  output logic       halted,
  output logic       expired,
  output logic       expired_pulse,
  output logic       warn,
  output logic       digits_on
);

  localparam logic [3:0] INIT_TENS = 4'(ROUND_SECS / 10);
  localparam logic [3:0] INIT_ONES = 4'(ROUND_SECS % 10);
  localparam logic [6:0] WARN_LIM  = 7'(WARN_SECS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_HALT,
    S_EXPIRED
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       tick_prev_q;
  logic       exp_pulse_q, exp_pulse_d;
  logic       tick;
  logic       count_zero;
  logic       count_one;
  logic [6:0] count_bin;

  assign tick       = clk_1hz & ~tick_prev_q;
  assign count_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign count_one  = (tens_q == 4'd0) && (ones_q == 4'd1);
  assign count_bin  = ({3'd0, tens_q} * 7'd10) + {3'd0, ones_q};

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tens_q      <= INIT_TENS;
      ones_q      <= INIT_ONES;
      tick_prev_q <= 1'b0;
      exp_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      tick_prev_q <= clk_1hz;
      exp_pulse_q <= exp_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    exp_pulse_d = 1'b0;
    if (start) begin
      state_d = S_RUN;
      tens_d  = INIT_TENS;
      ones_d  = INIT_ONES;
    end else if (solved && (state_q == S_RUN || state_q == S_PAUSE)) begin
      state_d = S_HALT;
    end else if (pause && state_q == S_RUN) begin
      state_d = S_PAUSE;
    end else if (pause && state_q == S_PAUSE) begin
      state_d = S_RUN;
    end else if (tick && state_q == S_RUN) begin
      if (count_one) begin
        state_d     = S_EXPIRED;
        ones_d      = 4'd0;
        exp_pulse_d = 1'b1;
      end else if (!count_zero) begin
        // BCD borrow: ones wraps to 9 and takes one from tens
        if (ones_q != 4'd0) begin
          ones_d = ones_q - 4'd1;
        end else begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end
      end
    end
  end

  assign sec_tens      = tens_q;
  assign sec_ones      = ones_q;
  assign running       = (state_q == S_RUN);
  assign paused        = (state_q == S_PAUSE);
  assign halted        = (state_q == S_HALT);
  assign expired       = (state_q == S_EXPIRED);
  assign expired_pulse = exp_pulse_q;
  assign warn          = running & ~count_zero & (count_bin <= WARN_LIM);

  always_comb begin
    digits_on = clk_blink;
    if (state_q == S_IDLE || state_q == S_HALT || (running && !warn)) begin
      digits_on = 1'b1;
    end
  end

endmodule

// File: tb/tb_round_timer.sv
// Directed test-plan walk followed by random button/tick traffic, checked against an integer-seconds model.
module tb_round_timer;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1hz = 1'b0;
  logic       clk_blink = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       solved = 1'b0;
  logic [3:0] sec_tens, sec_ones;
  logic       running, paused, halted, expired, expired_pulse, warn, digits_on;

  round_timer #(.ROUND_SECS(12), .WARN_SECS(5)) dut (
    .clk_in(clk_in), .rst(rst), .clk_1hz(clk_1hz), .clk_blink(clk_blink),
    .start(start), .pause(pause), .solved(solved),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .paused(paused), .halted(halted), .expired(expired),
    .expired_pulse(expired_pulse), .warn(warn), .digits_on(digits_on)
  );

  always #5 clk_in = ~clk_in;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_HALT = 3, M_EXP = 4;

  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc_n = 0;
  int   m_mode = M_IDLE;
  int   m_rem = 12;
  logic m_prev_hz = 1'b0;
  logic m_pulse = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic check_outputs();
    logic w, d;
    w = (m_mode == M_RUN) && (m_rem > 0) && (m_rem <= 5);
    d = (m_mode == M_IDLE || m_mode == M_HALT || (m_mode == M_RUN && !w)) ? 1'b1 : clk_blink;
    chk("sec_tens", 8'(sec_tens), 8'(m_rem / 10));
    chk("sec_ones", 8'(sec_ones), 8'(m_rem % 10));
    chk("running", 8'(running), 8'(m_mode == M_RUN));
    chk("paused", 8'(paused), 8'(m_mode == M_PAUSE));
    chk("halted", 8'(halted), 8'(m_mode == M_HALT));
    chk("expired", 8'(expired), 8'(m_mode == M_EXP));
    chk("expired_pulse", 8'(expired_pulse), 8'(m_pulse));
    chk("warn", 8'(warn), 8'(w));
    chk("digits_on", 8'(digits_on), 8'(d));
  endtask

  // One clock: drive inputs, advance the model by the same event, check after the edge.
  task automatic cyc(input logic r, input logic st, input logic pa, input logic so, input logic hz);
    logic tick;
    rst = r; start = st; pause = pa; solved = so; clk_1hz = hz;
    clk_blink = cyc_n[2];
    cyc_n++;
    tick = hz && !m_prev_hz;
    m_prev_hz = hz;
    m_pulse = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_rem = 12; m_prev_hz = 1'b0;
    end else if (st) begin
      m_mode = M_RUN; m_rem = 12;
    end else if (so && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
      m_mode = M_HALT;
    end else if (pa && m_mode == M_RUN) begin
      m_mode = M_PAUSE;
    end else if (pa && m_mode == M_PAUSE) begin
      m_mode = M_RUN;
    end else if (tick && m_mode == M_RUN) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_mode = M_EXP; m_pulse = 1'b1;
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic hz_edge();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic expect_digits(input string tag, input int v);
    chk({tag, "_tens"}, 8'(sec_tens), 8'(v / 10));
    chk({tag, "_ones"}, 8'(sec_ones), 8'(v % 10));
  endtask

  initial begin
    logic hz;
    int   hold;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    expect_digits("reset", 12);
    chk("reset_digits_on", 8'(digits_on), 8'd1);

    repeat (5) hz_edge();
    expect_digits("idle_no_dec", 12);

    cyc(0, 1, 0, 0, 0);
    chk("start_running", 8'(running), 8'd1);
    hz_edge(); expect_digits("first_dec", 11);
    hz_edge(); expect_digits("second_dec", 10);
    hz_edge(); expect_digits("bcd_borrow", 9);
    repeat (3) hz_edge();
    chk("warn_off_at_06", 8'(warn), 8'd0);
    hz_edge();
    chk("warn_on_at_05", 8'(warn), 8'd1);
    repeat (4) hz_edge(); expect_digits("at_one", 1);
    hz_edge(); expect_digits("at_zero", 0);
    chk("expired_flag", 8'(expired), 8'd1);
    chk("pulse_gone", 8'(expired_pulse), 8'd0);
    repeat (2) hz_edge(); expect_digits("hold_zero", 0);

    cyc(0, 1, 0, 0, 0);
    repeat (4) hz_edge(); expect_digits("reach_08", 8);
    cyc(0, 0, 1, 0, 0);
    chk("paused_flag", 8'(paused), 8'd1);
    repeat (4) hz_edge(); expect_digits("pause_hold", 8);
    cyc(0, 0, 1, 0, 0);
    hz_edge(); expect_digits("resume_dec", 7);
    cyc(0, 0, 0, 1, 0);
    chk("halted_flag", 8'(halted), 8'd1);
    cyc(0, 0, 1, 0, 0);
    repeat (2) hz_edge(); expect_digits("halt_frozen", 7);
    chk("halt_digits_on", 8'(digits_on), 8'd1);
    cyc(0, 1, 0, 0, 0); expect_digits("restart", 12);

    repeat (6) hz_edge(); expect_digits("reach_06", 6);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1);
    expect_digits("start_wins", 12);
    chk("start_wins_run", 8'(running), 8'd1);
    repeat (8) hz_edge(); expect_digits("reach_04", 4);
    cyc(1, 0, 0, 0, 0);
    expect_digits("mid_reset", 12);
    chk("mid_reset_run", 8'(running), 8'd0);

    hz = 1'b0;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        hz = ~hz;
        hold = $urandom_range(1, 5);
      end
      hold--;
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0), hz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/round_timer.md
Name: round_timer

Overview:
- Countdown round timer for the 24-game.
- Consumes the slow clocks from the clock generator as level signals sampled in the 100 MHz domain. Edge-detects the 1 Hz clock into a per-second tick.
- Sequences a BCD seconds countdown through idle/run/pause/halt/expire states, driven by debounced button pulses and the game's "solved" event.
- Provides BCD digits, status flags and a digit-enable (blink) signal to the seven-segment display path.

Parameters:
- ROUND_SECS, 60: round length in seconds. Legal range 1..99.
- WARN_SECS, 10: remaining-time threshold for the warning/blink phase. Legal range 0..ROUND_SECS.

Ports:
- clk_in  input  1  system clock, 100 MHz
- rst  input  1  synchronous, active-high reset
- clk_1hz  input  1  1 Hz square wave from clock generator, synchronous to clk_in
- clk_blink  input  1  ~3 Hz square wave from clock generator, synchronous to clk_in
- start  input  1  one-cycle pulse from debouncer: start/restart round
- pause  input  1  one-cycle pulse from debouncer: toggle pause
- solved  input  1  one-cycle pulse: player reached 24, freeze timer
- sec_tens  output  4  BCD tens digit of remaining seconds
- sec_ones  output  4  BCD ones digit of remaining seconds
- running  output  1  high in RUN
- paused  output  1  high in PAUSE
- halted  output  1  high in HALT
- expired  output  1  high in EXPIRED
- expired_pulse  output  1  one-cycle pulse on entry to EXPIRED
- warn  output  1  RUN and 0 < remaining <= WARN_SECS
- digits_on  output  1  display enable for timer digits

Behaviour:
- Clock and reset:
  - Single clock clk_in.
  - All state is updated on posedge clk_in. rst is sampled there only.
- Reset:
  - state = IDLE; count = BCD(ROUND_SECS); tick_prev = 0.
  - Flags running/paused/halted/expired/expired_pulse/warn = 0; digits_on = 1.
- Tick detection:
  - tick = clk_1hz & ~tick_prev, where tick_prev is a one-cycle delayed copy of clk_1hz.
  - Exactly one tick per rising edge of clk_1hz.
- States:
  - IDLE, RUN, PAUSE, HALT, EXPIRED.
- Priority each cycle: rst > start > solved > pause > tick.
  - At most one action is applied per cycle. Lower-priority events in the same cycle are discarded, not queued.
- Transitions:
  - start, any state: count <= BCD(ROUND_SECS), state <= RUN. This includes restarting mid-round and restarting from PAUSE.
  - solved in RUN or PAUSE: state <= HALT, count frozen. Ignored in IDLE, HALT and EXPIRED.
  - pause in RUN: state <= PAUSE. pause in PAUSE: state <= RUN. Ignored in other states.
  - tick in RUN with count > 1: decrement count.
  - tick in RUN with count == 1: count <= 0, state <= EXPIRED, expired_pulse = 1 for that next cycle only.
  - tick in IDLE, PAUSE, HALT or EXPIRED: ignored. Ticks are not accumulated while paused.
- Arithmetic:
  - count is held as two BCD digits.
  - Decrement: if ones != 0 then ones - 1; else ones = 9 and tens - 1.
  - Digits are always 0..9. No underflow below 00.
- Timing:
  - The first decrement after start occurs on the next clk_1hz rising edge. The first second is therefore 0..1 s long; this is accepted.
  - Outputs are registered. Counter and state change one cycle after the qualifying edge or pulse.
- Status flags:
  - running/paused/halted/expired decode the registered state.
  - warn = running & (count != 0) & (count <= WARN_SECS).
- digits_on:
  - 1 in IDLE, in HALT, and in RUN without warn.
  - Equals clk_blink in PAUSE, in EXPIRED, and in RUN with warn.
  - Combinational from registered state/flags and clk_blink.
- Reset mid-operation: unconditional return to reset values. A pending tick is lost.

Test Plan:
- Use ROUND_SECS=12, WARN_SECS=5, and drive clk_1hz/clk_blink directly at a fast period.
- Reset, no stimulus, 5 clk_1hz edges -> IDLE, sec_tens=1, sec_ones=2, digits_on=1, no decrement.
- start, then 3 clk_1hz rising edges -> digits 11, 10, 09 (ones wraps to 9, tens 1->0), running=1. warn asserts only when the count reaches 05.
- Countdown continues to 01, then one more edge -> 00, expired=1, expired_pulse high exactly one cycle, digits_on follows clk_blink. Further edges keep 00.
- At 08: pause -> paused=1, 4 edges leave 08. pause again -> RUN, next edge -> 07.
- At 07: solved -> halted=1, digits frozen at 07, digits_on=1. Subsequent pause and tick edges are ignored. start -> 12, RUN.
- start, solved and a tick edge in the same cycle while at 06 -> count=12, state RUN (start wins). rst asserted at 04 during RUN -> IDLE, 12, all flags 0 on the next cycle.
